// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control/status bundle between a sweep requester and the sweeper
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] exp_tt;
  logic       busy;
  logic       done;
  logic [7:0] tt;
  logic       pass;
  logic [7:0] mismatch;
  logic [7:0] fail_count;

  modport master (
    output start, abort, exp_tt,
    input  busy, done, tt, pass, mismatch, fail_count
  );

  modport slave (
    input  start, abort, exp_tt,
    output busy, done, tt, pass, mismatch, fail_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks a 3-input gate through all 8 vectors and captures its truth table
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  truth_table_sweeper_if.slave        ctl,
  output logic                        in1,
  output logic                        in2,
  output logic                        in3,
  input  logic                        dut_out
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] tt_q, tt_d;
  logic       pass_q, pass_d;
  logic [7:0] mismatch_q, mismatch_d;
  logic [7:0] fail_q, fail_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [2:0] vec_q, vec_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    tt_d       = tt_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // abort outranks a simultaneous start
        if (ctl.start && !ctl.abort) begin
          state_d    = APPLY;
          idx_d      = 3'd0;
          cnt_d      = 8'd0;
          exp_d      = ctl.exp_tt;
          tt_d       = 8'd0;
          pass_d     = 1'b0;
          mismatch_d = 8'd0;
        end
      end
      APPLY: begin
        if (ctl.abort) begin
          state_d    = IDLE;
          idx_d      = 3'd0;
          cnt_d      = 8'd0;
          tt_d       = 8'd0;
          pass_d     = 1'b0;
          mismatch_d = 8'd0;
        end else if (cnt_q == LAST_CNT) begin
          tt_d[~idx_q] = dut_out;
          cnt_d        = 8'd0;
          if (idx_q == 3'd7) state_d = DONE;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        idx_d      = 3'd0;
        done_d     = 1'b1;
        pass_d     = (tt_q == exp_q);
        mismatch_d = tt_q ^ exp_q;
        if ((tt_q != exp_q) && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // registered outputs follow the state being entered
    busy_d = (state_d != IDLE);
    vec_d  = (state_d == APPLY) ? idx_d : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 8'd0;
      exp_q      <= 8'd0;
      tt_q       <= 8'd0;
      pass_q     <= 1'b0;
      mismatch_q <= 8'd0;
      fail_q     <= 8'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      vec_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      tt_q       <= tt_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      vec_q      <= vec_d;
    end
  end

  assign {in1, in2, in3}  = vec_q;
  assign ctl.busy         = busy_q;
  assign ctl.done         = done_q;
  assign ctl.tt           = tt_q;
  assign ctl.pass         = pass_q;
  assign ctl.mismatch     = mismatch_q;
  assign ctl.fail_count   = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed bench for truth_table_sweeper with a behavioural gate model
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] model_tt = 8'h2C;

  truth_table_sweeper_if ctl4 ();
  truth_table_sweeper_if ctl1 ();

  logic a4, b4, c4, g4;
  logic a1, b1, c1, g1;
  logic [2:0] v4, v1;
  assign v4 = {a4, b4, c4};
  assign v1 = {a1, b1, c1};
  assign g4 = model_tt[~v4];
  assign g1 = model_tt[~v1];

  truth_table_sweeper #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ctl(ctl4.slave),
    .in1(a4), .in2(b4), .in3(c4), .dut_out(g4)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(ctl1.slave),
    .in1(a1), .in2(b1), .in3(c1), .dut_out(g1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start a sweep on the 4-cycle instance; lat counts edges from acceptance to done
  task automatic run_sweep(input logic [7:0] exp, output int lat, output int seq_err);
    @(negedge clk);
    ctl4.start  = 1'b1;
    ctl4.exp_tt = exp;
    @(negedge clk);
    ctl4.start = 1'b0;
    lat = 0;
    seq_err = 0;
    while (!ctl4.done && lat < 200) begin
      if (lat < 32 && v4 != 3'(lat / 4)) seq_err++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, seq_err, ndone, d0, d1, k, fc_before;

  initial begin
    ctl4.start = 1'b0; ctl4.abort = 1'b0; ctl4.exp_tt = 8'h00;
    ctl1.start = 1'b0; ctl1.abort = 1'b0; ctl1.exp_tt = 8'h00;
    #1;
    expect_eq("rst_busy", ctl4.busy, 0);
    expect_eq("rst_in", v4, 0);
    expect_eq("rst_tt_fc", {ctl4.tt, ctl4.fail_count, ctl4.mismatch}, 0);
    expect_eq("rst_done_pass", {ctl4.done, ctl4.pass}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(8'h2C, lat, seq_err);
    expect_eq("pass_latency", lat, 33);
    expect_eq("pass_vec_seq", seq_err, 0);
    expect_eq("pass_tt", ctl4.tt, 8'h2C);
    expect_eq("pass_pass", ctl4.pass, 1);
    expect_eq("pass_mismatch", ctl4.mismatch, 8'h00);
    expect_eq("pass_fc", ctl4.fail_count, 0);
    expect_eq("done_busy_low", ctl4.busy, 0);
    @(negedge clk);
    expect_eq("done_one_cycle", ctl4.done, 0);
    expect_eq("tt_holds_idle", ctl4.tt, 8'h2C);

    run_sweep(8'h2D, lat, seq_err);
    expect_eq("fail_tt", ctl4.tt, 8'h2C);
    expect_eq("fail_pass", ctl4.pass, 0);
    expect_eq("fail_mismatch", ctl4.mismatch, 8'h01);
    expect_eq("fail_fc", ctl4.fail_count, 1);

    // abort and start together in IDLE: nothing happens
    @(negedge clk);
    ctl4.start = 1'b1; ctl4.abort = 1'b1; ctl4.exp_tt = 8'h2C;
    @(negedge clk);
    ctl4.start = 1'b0; ctl4.abort = 1'b0;
    expect_eq("abort_wins_busy", ctl4.busy, 0);
    expect_eq("abort_wins_tt", ctl4.tt, 8'h2C);

    // start held high: back-to-back sweeps every 34 cycles
    ctl4.start = 1'b1;
    @(negedge clk);
    ndone = 0; d0 = -1; d1 = -1; seq_err = 0;
    for (int i = 0; i < 70; i++) begin
      if (ctl4.done) begin
        if (ndone == 0) d0 = i;
        else if (ndone == 1) d1 = i;
        ndone++;
      end
      if (i < 32 && v4 != 3'(i / 4)) seq_err++;
      @(negedge clk);
    end
    ctl4.start = 1'b0;
    expect_eq("held_ndone", ndone, 2);
    expect_eq("held_first_done", d0, 33);
    expect_eq("held_second_done", d1, 67);
    expect_eq("held_vec_seq", seq_err, 0);
    expect_eq("held_fc", ctl4.fail_count, 1);

    // the third sweep is in APPLY now; abort it
    expect_eq("held_busy", ctl4.busy, 1);
    ctl4.abort = 1'b1;
    @(negedge clk);
    ctl4.abort = 1'b0;
    expect_eq("abort_cleanup_busy", ctl4.busy, 0);

    // abort ten cycles after acceptance
    fc_before = 32'(ctl4.fail_count);
    @(negedge clk);
    ctl4.start = 1'b1; ctl4.exp_tt = 8'hFF;
    @(negedge clk);
    ctl4.start = 1'b0;
    repeat (10) @(negedge clk);
    ctl4.abort = 1'b1;
    @(negedge clk);
    ctl4.abort = 1'b0;
    expect_eq("abort_busy", ctl4.busy, 0);
    expect_eq("abort_in", v4, 0);
    expect_eq("abort_tt", ctl4.tt, 0);
    expect_eq("abort_pass_mm", {ctl4.pass, ctl4.mismatch}, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (ctl4.done) ndone++;
      @(negedge clk);
    end
    expect_eq("abort_no_done", ndone, 0);
    expect_eq("abort_fc", ctl4.fail_count, fc_before);

    // asynchronous reset once vector 101 is on the pins
    ctl4.start = 1'b1; ctl4.exp_tt = 8'h2C;
    @(negedge clk);
    ctl4.start = 1'b0;
    k = 0;
    while (v4 != 3'b101 && k < 100) begin
      @(negedge clk);
      k++;
    end
    expect_eq("reach_idx5", v4, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("async_rst_busy_in", {ctl4.busy, v4}, 0);
    expect_eq("async_rst_fc", ctl4.fail_count, 0);
    expect_eq("async_rst_tt_mm", {ctl4.tt, ctl4.mismatch, ctl4.pass, ctl4.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(8'h2C, lat, seq_err);
    expect_eq("post_rst_latency", lat, 33);
    expect_eq("post_rst_seq", seq_err, 0);
    expect_eq("post_rst_tt_pass", {ctl4.tt, ctl4.pass}, {8'h2C, 1'b1});

    // saturation of the failure counter
    for (int i = 1; i <= 256; i++) begin
      run_sweep(8'hD3, lat, seq_err);
      if (i == 1) begin
        expect_eq("sat_first_fc", ctl4.fail_count, 1);
        expect_eq("sat_mismatch", ctl4.mismatch, 8'hFF);
      end
      if (i == 255) expect_eq("sat_fc_255", ctl4.fail_count, 255);
      if (i == 256) expect_eq("sat_fc_256", ctl4.fail_count, 255);
    end
    expect_eq("sat_last_latency", lat, 33);

    // single settle cycle, different gate
    model_tt = 8'h96;
    @(negedge clk);
    ctl1.start = 1'b1; ctl1.exp_tt = 8'h96;
    @(negedge clk);
    ctl1.start = 1'b0;
    k = 0; seq_err = 0;
    while (!ctl1.done && k < 50) begin
      if (k < 8 && v1 != 3'(k)) seq_err++;
      @(negedge clk);
      k++;
    end
    expect_eq("s1_latency", k, 9);
    expect_eq("s1_seq", seq_err, 0);
    expect_eq("s1_tt", ctl1.tt, 8'h96);
    expect_eq("s1_pass_fc", {ctl1.pass, ctl1.fail_count}, {1'b1, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
